// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - multi-cycle RV32M multiply/divide execute unit
module riscv_muldiv_unit #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   count_q;
    logic            neg_quo_q, neg_rem_q, special_q;
    logic [XLEN-1:0] special_res_q;

    logic            in_signed, in_div_zero, in_ovf, in_special, fast_done, accept;
    logic [XLEN-1:0] in_special_res, in_mag_a, in_mag_b;

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign accept  = (state_q == S_IDLE) && valid_i && !flush_i;

    // Request decode: special cases are recognised on the raw operands
    assign in_signed   = ~funct3_i[0];
    assign in_div_zero = (rs2_i == '0);
    assign in_ovf      = in_signed && (rs1_i == MIN_INT) && (rs2_i == '1);
    assign in_special  = in_div_zero || in_ovf;
    assign fast_done   = FAST_SPECIAL && funct3_i[2] && in_special;
    assign in_mag_a    = (in_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign in_mag_b    = (in_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

    always_comb begin
        in_special_res = '0;
        if (in_div_zero) begin
            in_special_res = funct3_i[1] ? rs1_i : '1;
        end else begin
            in_special_res = funct3_i[1] ? '0 : MIN_INT;
        end
    end

    // Multiply: operands extended to 2*XLEN so one unsigned product serves all variants
    logic                a_sx, b_sx;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     mul_res;
    assign a_sx    = ((op_q == 2'b01) || (op_q == 2'b10)) && a_q[XLEN-1];
    assign b_sx    = (op_q == 2'b01) && b_q[XLEN-1];
    assign prod    = {{XLEN{a_sx}}, a_q} * {{XLEN{b_sx}}, b_q};
    assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Restoring divide step on magnitudes
    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] rem_next, quo_next, quo_fix, rem_fix, div_res;
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        trial    = shifted - {1'b0, dvs_q};
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo_q[XLEN-2:0], 1'b1};
        end
        quo_fix = neg_quo_q ? -quo_next : quo_next;
        rem_fix = neg_rem_q ? -rem_next : rem_next;
        div_res = special_q ? special_res_q : (op_q[1] ? rem_fix : quo_fix);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (valid_i) begin
                if (!funct3_i[2])   state_d = S_MUL;
                else if (fast_done) state_d = S_DONE;
                else                state_d = S_DIV;
            end
            S_MUL:  state_d = S_DONE;
            S_DIV:  if (count_q == LAST) state_d = S_DONE;
            S_DONE: if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            result_o      <= '0;
            rd_o          <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            count_q       <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q          <= funct3_i[1:0];
                rd_q          <= rd_i;
                a_q           <= rs1_i;
                b_q           <= rs2_i;
                rem_q         <= '0;
                quo_q         <= in_mag_a;
                dvs_q         <= in_mag_b;
                count_q       <= '0;
                neg_quo_q     <= in_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                neg_rem_q     <= in_signed && rs1_i[XLEN-1];
                special_q     <= in_special;
                special_res_q <= in_special_res;
                if (fast_done) begin
                    result_o <= in_special_res;
                    rd_o     <= rd_i;
                end
            end else if (!flush_i) begin
                if (state_q == S_MUL) begin
                    result_o <= mul_res;
                    rd_o     <= rd_q;
                end
                if (state_q == S_DIV) begin
                    rem_q   <= rem_next;
                    quo_q   <= quo_next;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        result_o <= div_res;
                        rd_o     <= rd_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb/tb_riscv_muldiv_unit.sv - bench for riscv_muldiv_unit at XLEN=32 (fast specials) and XLEN=16 (iterating)
module tb_riscv_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd = '0;

    logic        ready32, valid32, ready16, valid16;
    logic [31:0] res32;
    logic [15:0] res16;
    logic [4:0]  rdo32, rdo16;

    int checks = 0;
    int errors = 0;

    logic        p32 = 1'b0, p16 = 1'b0;
    logic [31:0] e32 = '0;
    logic [15:0] e16 = '0;
    logic [4:0]  erd = '0;

    always #5 clk = ~clk;

    riscv_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready32),
        .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .valid_o(valid32),
        .ready_i(ready_i), .result_o(res32), .rd_o(rdo32));

    riscv_muldiv_unit #(.XLEN(16), .FAST_SPECIAL(1'b0)) dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready16),
        .funct3_i(funct3), .rs1_i(rs1[15:0]), .rs2_i(rs2[15:0]), .rd_i(rd), .valid_o(valid16),
        .ready_i(ready_i), .result_o(res16), .rd_o(rdo16));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit two's complement values
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a_in,
                                           input logic [31:0] b_in, input int w);
        longint      mask, ua, ub, sa, sb, r, min_s;
        logic [63:0] up;
        mask  = (longint'(1) << w) - 1;
        ua    = longint'({32'b0, a_in}) & mask;
        ub    = longint'({32'b0, b_in}) & mask;
        sa    = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb    = ub[w-1] ? ub - (longint'(1) << w) : ub;
        min_s = -(longint'(1) << (w - 1));
        case (f3)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: begin up = 64'(ua) * 64'(ub); r = longint'(up >> w); end
            3'd4: r = (ub == 0) ? mask : ((sa == min_s && sb == -1) ? ua : sa / sb);
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? ua : ((sa == min_s && sb == -1) ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'hFFFF_8000;
            6: return 32'h0000_7FFF;
            default: return $urandom;
        endcase
    endfunction

    // Single compare process: any valid result must match the outstanding expectation
    always @(negedge clk) begin
        if (rst_ni) begin
            if (valid32) begin
                if (!p32) check("spurious_valid32", 1, 0);
                else begin
                    check("result32", res32, e32);
                    check("rd32", rdo32, erd);
                end
            end
            if (valid16) begin
                if (!p16) check("spurious_valid16", 1, 0);
                else begin
                    check("result16", res16, e16);
                    check("rd16", rdo16, erd);
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input int hold);
        int n, f32, f16, l32, l16;
        logic s32, s16, special32;
        special32 = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        l32 = !f3[2] ? 2 : (special32 ? 1 : 33);
        l16 = !f3[2] ? 2 : 17;
        @(negedge clk);
        check("ready32_idle", ready32, 1);
        check("ready16_idle", ready16, 1);
        funct3 = f3; rs1 = a; rs2 = b; rd = t; valid_i = 1'b1;
        e32 = ref_op(f3, a, b, 32);
        e16 = 16'(ref_op(f3, a, b, 16));
        erd = t; p32 = 1'b1; p16 = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        n = 0; f32 = 0; f16 = 0; s32 = 1'b0; s16 = 1'b0;
        while ((!s32 || !s16) && n < 100) begin
            @(negedge clk);
            n++;
            if (valid32 && !s32) begin s32 = 1'b1; f32 = n; end
            if (valid16 && !s16) begin s16 = 1'b1; f16 = n; end
        end
        check("latency32", f32, l32);
        check("latency16", f16, l16);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ready32_done", ready32, 0);
            check("valid32_held", valid32, 1);
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0; p32 = 1'b0; p16 = 1'b0;
        @(negedge clk);
        check("ready32_after_hs", ready32, 1);
        check("ready16_after_hs", ready16, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("rst_ready", ready32, 1);
        check("rst_valid", valid32, 0);
        check("rst_result", res32, 0);
        check("rst_rd", rdo32, 0);

        check("pin_mul", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32), 32'hFFFF_FFEB);
        check("pin_mulhu", ref_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFE);
        check("pin_mulh", ref_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32), 32'h4000_0000);
        check("pin_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFF);
        check("pin_div", ref_op(3'd4, 32'hFFFF_FFEC, 32'd3, 32), 32'hFFFF_FFFA);
        check("pin_rem", ref_op(3'd6, 32'hFFFF_FFEC, 32'd3, 32), 32'hFFFF_FFFE);
        check("pin_divu", ref_op(3'd5, 32'd100, 32'd7, 32), 32'd14);
        check("pin_remu", ref_op(3'd7, 32'd100, 32'd7, 32), 32'd2);
        check("pin_div0", ref_op(3'd4, 32'd5, 32'd0, 32), 32'hFFFF_FFFF);
        check("pin_rem0", ref_op(3'd6, 32'd5, 32'd0, 32), 32'd5);
        check("pin_ovf_div", ref_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'h8000_0000);
        check("pin_ovf_rem", ref_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'd0);
        check("pin_ovf16", ref_op(3'd4, 32'h0000_8000, 32'h0000_FFFF, 16), 32'h0000_8000);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd7, 0);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd8, 10);
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd10, 0);
        run_op(3'd4, 32'd5, 32'd0, 5'd11, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd12, 2);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
        run_op(3'd4, 32'hFFFF_8000, 32'hFFFF_FFFF, 5'd15, 0);

        // Flush during DIV iteration 15: no result may ever appear
        @(negedge clk);
        funct3 = 3'd4; rs1 = 32'hFFFF_FFEC; rs2 = 32'd3; rd = 5'd20; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk) flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        check("flush_ready32", ready32, 1);
        check("flush_ready16", ready16, 1);
        check("flush_valid32", valid32, 0);
        repeat (40) @(negedge clk);

        // Flush beats an accept in the same cycle
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd = 5'd21; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("flush_accept_ready", ready32, 1);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 120; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(1, 31)),
                   $urandom_range(0, 3));

        // Reset in the middle of a multiply clears everything
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 0);
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13; rd = 5'd22; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk) rst_ni = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("rstmul_ready32", ready32, 1);
        check("rstmul_valid32", valid32, 0);
        check("rstmul_result32", res32, 0);
        check("rstmul_rd32", rdo32, 0);
        check("rstmul_ready16", ready16, 1);
        check("rstmul_valid16", valid16, 0);
        check("rstmul_result16", res16, 0);
        check("rstmul_rd16", rdo16, 0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
